// File: rtl/matrix_vec_mul_if.sv
// Operand/result handshake bundle for matrix_vec_mul: 2x2 bit matrix (a..d),
// 2-bit vector (e, f) in, 2-bit result (g, h) out, valid/ready on each side.
interface matrix_vec_mul_if;
   logic in_valid;
   logic in_ready;
   logic a;
   logic b;
   logic c;
   logic d;
   logic e;
   logic f;
   logic out_valid;
   logic out_ready;
   logic g;
   logic h;

   // Producer of operands and consumer of results (testbench / upstream logic)
   modport master (
      output in_valid,
      input  in_ready,
      output a,
      output b,
      output c,
      output d,
      output e,
      output f,
      input  out_valid,
      output out_ready,
      input  g,
      input  h
   );

   // The multiplier itself
   modport slave (
      input  in_valid,
      output in_ready,
      input  a,
      input  b,
      input  c,
      input  d,
      input  e,
      input  f,
      output out_valid,
      input  out_ready,
      output g,
      output h
   );
endinterface

// File: rtl/matrix_vec_mul.sv
// 2x2 bit-matrix times 2-bit vector with a one-deep registered output stage.
// Define MATRIX_VEC_MUL_GF2_EN for XOR accumulation (GF(2)); default accumulates with OR.
module matrix_vec_mul (
   input  logic                  clk,
   input  logic                  rst_n,
   matrix_vec_mul_if.slave       bus
);

   logic in_xfer_s;
   logic out_xfer_s;
   logic g_next_s;
   logic h_next_s;
   logic out_valid_next_s;
   logic g_r;
   logic h_r;
   logic out_valid_r;

   // Accumulate two partial products according to the selected algebra.
   function automatic logic acc_f(input logic x, input logic y);
`ifdef MATRIX_VEC_MUL_GF2_EN
      return x ^ y;
`else
      return x | y;
`endif
   endfunction

   // Handshake decode; the stage accepts new data in the same cycle it drains.
   always_comb begin
      bus.in_ready = (!out_valid_r) || bus.out_ready;
      in_xfer_s    = bus.in_valid && bus.in_ready;
      out_xfer_s   = out_valid_r && bus.out_ready;
   end

   // Next-state for the result register and its valid flag.
   always_comb begin
      g_next_s         = g_r;
      h_next_s         = h_r;
      out_valid_next_s = out_valid_r;
      if (in_xfer_s) begin
         g_next_s         = acc_f(bus.a & bus.e, bus.b & bus.f);
         h_next_s         = acc_f(bus.c & bus.e, bus.d & bus.f);
         out_valid_next_s = 1'b1;
      end else if (out_xfer_s) begin
         out_valid_next_s = 1'b0;
      end else begin
         out_valid_next_s = out_valid_r;
      end
   end

   // Result register; reset wins over any transfer in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         g_r         <= 1'b0;
         h_r         <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         g_r         <= g_next_s;
         h_r         <= h_next_s;
         out_valid_r <= out_valid_next_s;
      end
   end

   assign bus.g         = g_r;
   assign bus.h         = h_r;
   assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_matrix_vec_mul.sv
// Directed bench for matrix_vec_mul: reset, exhaustive sweep, mode difference,
// backpressure, back-to-back throughput and mid-stream reset.
module tb_matrix_vec_mul;

   logic clk;
   logic rst_n;
   int   checks_cnt;
   int   fail_cnt;

   matrix_vec_mul_if bus ();

   matrix_vec_mul dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic act, input logic exp);
      checks_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %b expected %b", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] v);
      {bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} = v;
   endtask

   function automatic logic ref_acc(input logic x, input logic y);
`ifdef MATRIX_VEC_MUL_GF2_EN
      return x ^ y;
`else
      return x | y;
`endif
   endfunction

   initial begin
      logic [5:0] v;
      logic       exp_g;
      logic       exp_h;
      checks_cnt = 0;
      fail_cnt   = 0;

      // Reset held two cycles while a full operand set is offered
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      drive(6'b111111);
      step();
      step();
      check_value("rst_out_valid", bus.out_valid, 1'b0);
      check_value("rst_g", bus.g, 1'b0);
      check_value("rst_h", bus.h, 1'b0);
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      step();
      check_value("rst_in_ready", bus.in_ready, 1'b1);
      check_value("rst_out_valid_after", bus.out_valid, 1'b0);

      // Exhaustive sweep at full throughput
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 64; i++) begin
         v = 6'(i);
         drive(v);
         exp_g = ref_acc(v[0] & v[4], v[1] & v[5]);
         exp_h = ref_acc(v[2] & v[4], v[3] & v[5]);
         step();
         check_value($sformatf("sweep_g_%0d", i), bus.g, exp_g);
         check_value($sformatf("sweep_h_%0d", i), bus.h, exp_h);
         check_value($sformatf("sweep_v_%0d", i), bus.out_valid, 1'b1);
      end
      bus.in_valid = 1'b0;
      drive(6'b000000);
      step();
      check_value("drain_out_valid", bus.out_valid, 1'b0);
`ifdef MATRIX_VEC_MUL_GF2_EN
      check_value("drain_g_hold", bus.g, 1'b0);
      check_value("drain_h_hold", bus.h, 1'b0);
`else
      check_value("drain_g_hold", bus.g, 1'b1);
      check_value("drain_h_hold", bus.h, 1'b1);
`endif

      // Mode difference: a=b=e=f=1, c=d=0
      bus.in_valid = 1'b1;
      drive(6'b110011);
      step();
`ifdef MATRIX_VEC_MUL_GF2_EN
      check_value("mode_g", bus.g, 1'b0);
`else
      check_value("mode_g", bus.g, 1'b1);
`endif
      check_value("mode_h", bus.h, 1'b0);
      bus.in_valid = 1'b0;
      step();

      // Backpressure: a=e=1 accepted, consumer stalls three cycles
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      drive(6'b010001);
      step();
      check_value("bp_accept_g", bus.g, 1'b1);
      check_value("bp_accept_v", bus.out_valid, 1'b1);
      drive(6'b010100);
      for (int k = 0; k < 3; k++) begin
         step();
         check_value($sformatf("bp_g_%0d", k), bus.g, 1'b1);
         check_value($sformatf("bp_h_%0d", k), bus.h, 1'b0);
         check_value($sformatf("bp_v_%0d", k), bus.out_valid, 1'b1);
         check_value($sformatf("bp_ready_%0d", k), bus.in_ready, 1'b0);
      end

      // Back-to-back: drain and load c=e=1 in the same cycle
      bus.out_ready = 1'b1;
      #1;
      check_value("b2b_in_ready", bus.in_ready, 1'b1);
      step();
      check_value("b2b_h", bus.h, 1'b1);
      check_value("b2b_g", bus.g, 1'b0);
      check_value("b2b_v", bus.out_valid, 1'b1);
      drive(6'b101000);
      step();
      check_value("b2b2_h", bus.h, 1'b1);
      check_value("b2b2_g", bus.g, 1'b0);
      check_value("b2b2_v", bus.out_valid, 1'b1);

      // Reset mid-stream with a pending stalled result
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      step();
      check_value("mid_pending_v", bus.out_valid, 1'b1);
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      drive(6'b111111);
      step();
      check_value("mid_rst_v", bus.out_valid, 1'b0);
      check_value("mid_rst_g", bus.g, 1'b0);
      check_value("mid_rst_h", bus.h, 1'b0);
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      step();
      check_value("mid_after_v", bus.out_valid, 1'b0);
      check_value("mid_after_g", bus.g, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/matrix_vec_mul.md
MATRIX_VEC_MUL -- requirements
Module: matrix_vec_mul

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 1 bit per matrix/vector element.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 in_valid  input  1  high when a..f carry a valid operand set.
REQ-005 in_ready  output  1  high when the block accepts an operand set this cycle.
REQ-006 a, b  input  1 each  matrix row 0 elements M[0][0], M[0][1].
REQ-007 c, d  input  1 each  matrix row 1 elements M[1][0], M[1][1].
REQ-008 e, f  input  1 each  vector elements V[0], V[1].
REQ-009 out_valid  output  1  high while g/h hold an unconsumed result.
REQ-010 out_ready  input  1  high when the consumer takes the result this cycle.
REQ-011 g, h  output  1 each  result R[0], R[1] of R = M x V.

Function
REQ-012 Input transfer SHALL occur in a cycle where in_valid and in_ready are both high; output transfer where out_valid and out_ready are both high.
REQ-013 in_ready SHALL equal (!out_valid || out_ready), combinationally, so a full output register accepts new data in the cycle it drains.
REQ-014 On an input transfer, g SHALL register (a AND e) ACC (b AND f) and h SHALL register (c AND e) ACC (d AND f), where ACC is defined in Configuration.
REQ-015 Latency SHALL be exactly 1 cycle: result and out_valid=1 appear on the clk edge that accepts the input.
REQ-016 Without an input transfer, out_valid SHALL clear on an output transfer and otherwise hold; g/h SHALL hold their value while out_valid=1 and out_ready=0.
REQ-017 Simultaneous input and output transfer SHALL load the new result and keep out_valid=1 (full throughput, one result per cycle).
REQ-018 a..f SHALL be ignored in any cycle without an input transfer; they may change freely.
REQ-019 When out_valid=0, g and h SHALL retain their last registered value (0 after reset).
REQ-020 All outputs SHALL be glitch-free registered values except in_ready (combinational per REQ-013).

Reset
REQ-021 While rst_n=0 at a rising clk: out_valid=0, g=0, h=0; in_ready then reads 1.
REQ-022 Reset SHALL take priority over any simultaneous transfer; an operand set presented in a reset cycle SHALL be discarded.
REQ-023 Reset mid-operation SHALL drop any pending result; no result SHALL emerge from pre-reset inputs.

Configuration
REQ-024 Macro MATRIX_VEC_MUL_GF2_EN: when defined, ACC SHALL be XOR (arithmetic over GF(2)).
REQ-025 When MATRIX_VEC_MUL_GF2_EN is not defined, ACC SHALL be OR (Boolean semiring); interface and timing SHALL be identical in both builds.

Verification
REQ-026 Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, g=0, h=0, in_ready=1 after release.
REQ-027 Exhaustive sweep: all 64 values of {f,e,d,c,b,a}, out_ready=1 -> each result one cycle later matches REQ-014 under the active build.
REQ-028 Mode difference: a=b=e=f=1, c=d=0 -> g=1,h=0 without macro; g=0,h=0 with MATRIX_VEC_MUL_GF2_EN.
REQ-029 Backpressure: a=1,e=1 accepted, out_ready=0 for 3 cycles -> g=1 held, out_valid=1, in_ready=0; new inputs ignored until drained.
REQ-030 Back-to-back: out_valid=1, out_ready=1, in_valid=1 with c=e=1 -> next cycle h=1, out_valid stays 1, no bubble.
REQ-031 Reset mid-stream: result pending with out_ready=0, assert rst_n=0 -> out_valid=0 next edge, g=h=0.
